cfg_write_arbiter: RTL and testbench
====================================

CFG_WRITE_ARBITER -- requirements
Module: cfg_write_arbiter

Interface
REQ-001 Parameters: none; all widths below are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 wr0_valid / wr0_addr / wr0_data  input  1/7/8  requester 0 (SPI frame decoder) write request.
REQ-005 wr0_ready  output  1  requester 0 grant, registered.
REQ-006 wr1_valid / wr1_addr / wr1_data  input  1/7/8  requester 1 (on-chip sequencer) write request.
REQ-007 wr1_ready  output  1  requester 1 grant, registered.
REQ-008 err_clr  input  1  one-cycle clear of err_addr.
REQ-009 en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  output  8 each  config register bank, addresses 0x00-0x04 in that order.
REQ-010 err_addr  output  1  sticky flag: a write targeted an address above 0x04.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and COMMIT.
REQ-013 In IDLE with at least one wrK_valid high in cycle N, the block SHALL latch the winner's addr/data, record the winner, and enter COMMIT at the edge ending cycle N.
REQ-014 In COMMIT (cycle N+1) the block SHALL drive wrK_ready=1 for the winner only; the transfer completes in that cycle (valid && ready).
REQ-015 At the edge ending cycle N+1 the block SHALL write the latched data to the addressed register (visible from cycle N+2) and return to IDLE.
REQ-016 Throughput: at most one write per 2 cycles; a requester held valid is re-arbitrated in the next IDLE cycle.
REQ-017 Requesters SHALL hold valid, addr and data stable until ready is seen; the block does not re-sample them in COMMIT.
REQ-018 wrK_valid high in COMMIT SHALL be ignored for that cycle, with no ready issued to the loser.
REQ-019 Only one ready SHALL be high in any cycle; ready SHALL never be high in IDLE.
REQ-020 Tie-break (both valid in IDLE) SHALL be defined by the Configuration section; a single valid requester always wins.
REQ-021 An address of 0x05-0x7F SHALL complete the handshake normally, leave all registers unchanged, and set err_addr at the commit edge.
REQ-022 err_addr SHALL clear on err_clr; if err_clr and a new invalid commit coincide, err_addr SHALL end set.
REQ-023 Writes to the same register SHALL apply in grant order; the last granted write wins.

Reset
REQ-024 With rst_n low at a rising edge, the block SHALL enter IDLE and clear all five registers, err_addr, busy, wr0_ready, wr1_ready and the latched addr/data to 0.
REQ-025 The same reset SHALL set the last-grant record to requester 1.
REQ-026 Reset asserted in COMMIT SHALL abort the pending write: no register is updated and ready is low from the next cycle.
REQ-027 The first arbitration SHALL occur in the first IDLE cycle with rst_n high.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN: when defined, a tie SHALL grant the requester not recorded as last granted, and the record updates on every grant.
REQ-029 Without ARB_ROUND_ROBIN_EN, a tie SHALL always grant requester 0 (fixed priority), and the last-grant record is unused.

Verification
REQ-030 wr0 write addr 0x04 data 0x80, valid in cycle 1 -> wr0_ready=1 in cycle 2 only; pwm_duty_cycle=0x80 from cycle 3; busy high in cycle 2 only.
REQ-031 Both valid continuously, wr0 addr 0x00 data 0xAA, wr1 addr 0x00 data 0x55, ARB_ROUND_ROBIN_EN defined -> grants alternate 0,1,0,1 every 2 cycles starting with requester 0; en_reg_out_7_0 alternates 0xAA/0x55.
REQ-032 Same stimulus without the macro -> wr0_ready pulses every 2 cycles; wr1_ready never asserts; en_reg_out_7_0 stays 0xAA.
REQ-033 wr1 addr 0x05 data 0xFF -> handshake completes; all registers unchanged; err_addr=1 until err_clr pulses; err_clr coincident with a second 0x05 commit -> err_addr stays 1.
REQ-034 wr0 addr 0x02 data 0x0F, rst_n low in the COMMIT cycle -> en_reg_pwm_7_0 stays 0x00; state IDLE; wr0_ready=0 from the next cycle.

Source files
------------

// File: rtl/cfg_write_arbiter.sv
// Two-requester arbiter in front of a five-entry configuration register bank.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to requester 0.
module cfg_write_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr0_valid,
    input  logic [6:0] wr0_addr,
    input  logic [7:0] wr0_data,
    output logic       wr0_ready,
    input  logic       wr1_valid,
    input  logic [6:0] wr1_addr,
    input  logic [7:0] wr1_data,
    output logic       wr1_ready,
    input  logic       err_clr,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       err_addr,
    output logic       busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    localparam int NUM_REGS = 5;

    state_t     state_reg, state_next;
    logic [6:0] addr_reg, addr_next;
    logic [7:0] data_reg, data_next;
    logic       ready0_reg, ready0_next;
    logic       ready1_reg, ready1_next;
    logic       err_reg, err_next;
    logic       commit;
    logic       grant;
    logic       tie_pick;
    logic [7:0] bank_reg  [NUM_REGS];
    logic [7:0] bank_next [NUM_REGS];

`ifdef ARB_ROUND_ROBIN_EN
    logic last_reg, last_next;

    // On a tie, favour whichever requester did not win most recently.
    assign tie_pick = ~last_reg;
`else
    assign tie_pick = 1'b0;
`endif

    // A lone requester always wins; tie_pick only matters when both ask.
    assign grant = (wr0_valid && wr1_valid) ? tie_pick : wr1_valid;

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        data_next   = data_reg;
        ready0_next = 1'b0;
        ready1_next = 1'b0;
        err_next    = err_reg & ~err_clr;
        commit      = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_next   = last_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (wr0_valid || wr1_valid) begin
                    state_next  = COMMIT;
                    addr_next   = grant ? wr1_addr : wr0_addr;
                    data_next   = grant ? wr1_data : wr0_data;
                    ready0_next = ~grant;
                    ready1_next = grant;
`ifdef ARB_ROUND_ROBIN_EN
                    last_next   = grant;
`endif
                end
            end
            COMMIT: begin
                state_next = IDLE;
                commit     = 1'b1;
                // A new out-of-range commit beats a coincident clear.
                if (addr_reg >= 7'(NUM_REGS)) begin
                    err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bank
            assign bank_next[gi] = (commit && addr_reg == 7'(gi)) ? data_reg : bank_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            data_reg   <= '0;
            ready0_reg <= 1'b0;
            ready1_reg <= 1'b0;
            err_reg    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_reg[i] <= '0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_reg   <= 1'b1;
`endif
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            data_reg   <= data_next;
            ready0_reg <= ready0_next;
            ready1_reg <= ready1_next;
            err_reg    <= err_next;
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_reg[i] <= bank_next[i];
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_reg   <= last_next;
`endif
        end
    end

    assign wr0_ready       = ready0_reg;
    assign wr1_ready       = ready1_reg;
    assign err_addr        = err_reg;
    assign busy            = (state_reg == COMMIT);
    assign en_reg_out_7_0  = bank_reg[0];
    assign en_reg_out_15_8 = bank_reg[1];
    assign en_reg_pwm_7_0  = bank_reg[2];
    assign en_reg_pwm_15_8 = bank_reg[3];
    assign pwm_duty_cycle  = bank_reg[4];

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Bench for cfg_write_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the grant/commit rules.
module tb_cfg_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr0_valid, wr1_valid;
    logic [6:0] wr0_addr, wr1_addr;
    logic [7:0] wr0_data, wr1_data;
    logic       wr0_ready, wr1_ready;
    logic       err_clr;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       err_addr, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cfg_write_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr0_valid       (wr0_valid),
        .wr0_addr        (wr0_addr),
        .wr0_data        (wr0_data),
        .wr0_ready       (wr0_ready),
        .wr1_valid       (wr1_valid),
        .wr1_addr        (wr1_addr),
        .wr1_data        (wr1_data),
        .wr1_ready       (wr1_ready),
        .err_clr         (err_clr),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .err_addr        (err_addr),
        .busy            (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
        err_clr   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h want 0", {en_reg_out_7_0, en_reg_out_15_8,
                     en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
        end
        checks++;
        if ({wr0_ready, wr1_ready, err_addr, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got rdy0/rdy1/err/busy=%b want 0000", {wr0_ready, wr1_ready, err_addr, busy});
        end
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        do_reset();
        tick();
        wr0_valid = 1'b1; wr0_addr = 7'h04; wr0_data = 8'h80;
        tick();
        checks++;
        if ({wr0_ready, wr1_ready, busy} !== 3'b101) begin
            errors++;
            $display("FAIL single_commit: got rdy0/rdy1/busy=%b want 101", {wr0_ready, wr1_ready, busy});
        end
        checks++;
        if (pwm_duty_cycle !== 8'h00) begin
            errors++;
            $display("FAIL single_early: got pwm_duty_cycle=%h want 00", pwm_duty_cycle);
        end
        wr0_valid = 1'b0;
        tick();
        checks++;
        if ({wr0_ready, wr1_ready, busy} !== 3'b000) begin
            errors++;
            $display("FAIL single_after: got rdy0/rdy1/busy=%b want 000", {wr0_ready, wr1_ready, busy});
        end
        checks++;
        if (pwm_duty_cycle !== 8'h80) begin
            errors++;
            $display("FAIL single_write: got pwm_duty_cycle=%h want 80", pwm_duty_cycle);
        end
        $display("test_single_write done");
    endtask

    task automatic test_tie();
        logic [7:0] want_reg;
        int         who;
        do_reset();
        wr0_valid = 1'b1; wr0_addr = 7'h00; wr0_data = 8'hAA;
        wr1_valid = 1'b1; wr1_addr = 7'h00; wr1_data = 8'h55;
        want_reg  = 8'h00;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i % 2 == 1) begin
`ifdef ARB_ROUND_ROBIN_EN
                who = ((i - 1) / 2) % 2;
`else
                who = 0;
`endif
                checks++;
                if (wr0_ready !== (who == 0) || wr1_ready !== (who == 1)) begin
                    errors++;
                    $display("FAIL tie_grant cycle %0d: got rdy0/rdy1=%b%b want grant to %0d",
                             i, wr0_ready, wr1_ready, who);
                end
                checks++;
                if (en_reg_out_7_0 !== want_reg) begin
                    errors++;
                    $display("FAIL tie_reg_hold cycle %0d: got %h want %h", i, en_reg_out_7_0, want_reg);
                end
                want_reg = (who == 0) ? 8'hAA : 8'h55;
            end else begin
                checks++;
                if ({wr0_ready, wr1_ready} !== 2'b00 || en_reg_out_7_0 !== want_reg) begin
                    errors++;
                    $display("FAIL tie_idle cycle %0d: got rdy=%b%b reg=%h want rdy=00 reg=%h",
                             i, wr0_ready, wr1_ready, en_reg_out_7_0, want_reg);
                end
            end
        end
        idle_inputs();
        tick();
        $display("test_tie done");
    endtask

    task automatic test_invalid_addr();
        do_reset();
        wr1_valid = 1'b1; wr1_addr = 7'h05; wr1_data = 8'hFF;
        tick();
        checks++;
        if ({wr0_ready, wr1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bad_addr_handshake: got rdy0/rdy1=%b%b want 01", wr0_ready, wr1_ready);
        end
        wr1_valid = 1'b0;
        tick();
        checks++;
        if (err_addr !== 1'b1) begin
            errors++;
            $display("FAIL bad_addr_err: got err_addr=%b want 1", err_addr);
        end
        checks++;
        if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'h0) begin
            errors++;
            $display("FAIL bad_addr_regs: got %h want 0", {en_reg_out_7_0, en_reg_out_15_8,
                     en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
        end
        tick();
        tick();
        checks++;
        if (err_addr !== 1'b1) begin
            errors++;
            $display("FAIL bad_addr_sticky: got err_addr=%b want 1", err_addr);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_addr !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got err_addr=%b want 0", err_addr);
        end
        wr1_valid = 1'b1;
        tick();
        wr1_valid = 1'b0;
        err_clr   = 1'b1;
        tick();
        err_clr   = 1'b0;
        checks++;
        if (err_addr !== 1'b1) begin
            errors++;
            $display("FAIL err_clr_vs_set: got err_addr=%b want 1", err_addr);
        end
        $display("test_invalid_addr done");
    endtask

    task automatic test_reset_in_commit();
        do_reset();
        wr0_valid = 1'b1; wr0_addr = 7'h02; wr0_data = 8'h0F;
        tick();
        checks++;
        if (wr0_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_commit: got wr0_ready=%b want 1", wr0_ready);
        end
        rst_n     = 1'b0;
        wr0_valid = 1'b0;
        tick();
        rst_n     = 1'b1;
        checks++;
        if ({wr0_ready, busy} !== 2'b00 || en_reg_pwm_7_0 !== 8'h00) begin
            errors++;
            $display("FAIL abort_write: got rdy0=%b busy=%b pwm_7_0=%h want 0 0 00",
                     wr0_ready, busy, en_reg_pwm_7_0);
        end
        tick();
        checks++;
        if ({wr0_ready, busy} !== 2'b00 || en_reg_pwm_7_0 !== 8'h00) begin
            errors++;
            $display("FAIL abort_after: got rdy0=%b busy=%b pwm_7_0=%h want 0 0 00",
                     wr0_ready, busy, en_reg_pwm_7_0);
        end
        $display("test_reset_in_commit done");
    endtask

    // Transaction model: a grant decided in a free cycle produces a ready in the
    // following cycle, and its write lands when that cycle ends.
    task automatic test_random();
        logic [7:0] m_regs [5];
        logic       m_err, m_last, m_pending;
        int         m_who;
        logic [6:0] m_addr;
        logic [7:0] m_data;
        logic [39:0] want_bank, got_bank;
        int         pick;

        do_reset();
        for (int r = 0; r < 5; r++) m_regs[r] = 8'h00;
        m_err = 1'b0; m_last = 1'b1; m_pending = 1'b0; m_who = 0; m_addr = '0; m_data = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            err_clr = ($urandom_range(0, 15) == 0);
            if (!wr0_valid && $urandom_range(0, 2) != 0) begin
                wr0_valid = 1'b1;
                wr0_addr  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
                wr0_data  = 8'($urandom);
            end
            if (!wr1_valid && $urandom_range(0, 2) != 0) begin
                wr1_valid = 1'b1;
                wr1_addr  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
                wr1_data  = 8'($urandom);
            end

            if (!rst_n) begin
                for (int r = 0; r < 5; r++) m_regs[r] = 8'h00;
                m_err = 1'b0; m_last = 1'b1; m_pending = 1'b0;
            end else if (m_pending) begin
                if (m_addr < 7'd5) m_regs[m_addr] = m_data;
                if (m_addr >= 7'd5) m_err = 1'b1;
                else if (err_clr) m_err = 1'b0;
                m_pending = 1'b0;
            end else begin
                if (err_clr) m_err = 1'b0;
                if (wr0_valid || wr1_valid) begin
                    if (wr0_valid && wr1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                        pick = m_last ? 0 : 1;
`else
                        pick = 0;
`endif
                    end else begin
                        pick = wr1_valid ? 1 : 0;
                    end
                    m_who     = pick;
                    m_last    = (pick == 1);
                    m_addr    = (pick == 1) ? wr1_addr : wr0_addr;
                    m_data    = (pick == 1) ? wr1_data : wr0_data;
                    m_pending = 1'b1;
                end
            end

            tick();

            checks++;
            if (wr0_ready !== (m_pending && m_who == 0) || wr1_ready !== (m_pending && m_who == 1)
                || busy !== m_pending) begin
                errors++;
                $display("FAIL rand_handshake cycle %0d: got rdy=%b%b busy=%b want rdy=%b%b busy=%b",
                         cyc, wr0_ready, wr1_ready, busy, m_pending && m_who == 0,
                         m_pending && m_who == 1, m_pending);
            end
            want_bank = {m_regs[0], m_regs[1], m_regs[2], m_regs[3], m_regs[4]};
            got_bank  = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
            checks++;
            if (got_bank !== want_bank || err_addr !== m_err) begin
                errors++;
                $display("FAIL rand_state cycle %0d: got bank=%h err=%b want bank=%h err=%b",
                         cyc, got_bank, err_addr, want_bank, m_err);
            end

            // A requester whose transfer just completed drops or reissues next cycle.
            if (m_pending && m_who == 0) wr0_valid = 1'b0;
            if (m_pending && m_who == 1) wr1_valid = 1'b0;
        end
        idle_inputs();
        tick();
        $display("test_random done");
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_write();
        test_tie();
        test_invalid_addr();
        test_reset_in_commit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
